// File: rtl/gain_stage_driver.sv
// gain_stage_driver: issues host commands to a param/data coprocessor stage
// as single-cycle strobes, collects data results and returns them over a
// valid/ready response channel, flagging stages that never answer.
// Optional build macro GAIN_STAGE_DRIVER_STATS_EN adds a saturating
// 16-bit response-handshake counter on port txn_count.
module gain_stage_driver #(
  parameter int unsigned MSB     = 31,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_is_param,
  input  logic [MSB:0] cmd_word,
  output logic         param_en,
  output logic [MSB:0] param_in,
  output logic         data_en,
  output logic [MSB:0] data_in,
  input  logic [MSB:0] stage_out,
  input  logic         stage_en_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [MSB:0] rsp_data,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
`ifdef GAIN_STAGE_DRIVER_STATS_EN
  ,
  output logic [15:0]  txn_count
`endif
);

  localparam int unsigned CNT_W = 8;
  // Last WAIT cycle index before giving up on the stage.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Command issue, result capture, timeout detection and response hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      param_en    <= 1'b0;
      param_in    <= '0;
      data_en     <= 1'b0;
      data_in     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      param_en <= 1'b0;
      data_en  <= 1'b0;
      // A timeout raised below overrides this clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_is_param) begin
              param_en <= 1'b1;
              param_in <= cmd_word;
            end else begin
              data_en  <= 1'b1;
              data_in  <= cmd_word;
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // A result on the final WAIT cycle still wins over the timeout.
          if (stage_en_out) begin
            rsp_data  <= stage_out;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GAIN_STAGE_DRIVER_STATS_EN
  // Saturating count of completed response handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_count <= '0;
    end else if (rsp_valid && rsp_ready && (txn_count != 16'hFFFF)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule
